temporizador_lavagem: RTL and testbench
=======================================

// Module: temporizador_lavagem
// PURPOSE
//  Phase timer feeding the washing-machine controller FSM. Watches the controller's mode
//  outputs (modo_agitar/modo_girar/modo_centrifugar), times each wash phase against
//  programmed durations and returns the completion levels tempo1, tempo2, tempo3, secar.
//  Also exposes remaining time, current phase and a sticky sequence-error flag.
// PARAMETERS
//  CNT_W     16    width of phase counter / tempo_restante
//  TICK_DIV  50000 clock cycles per time tick (>=1)
//  T_AGITAR  60    ticks for first agitation (drives tempo1)
//  T_GIRAR   30    ticks for spin/soak phase (drives tempo2)
//  T_AGITAR2 60    ticks for second agitation (drives tempo3)
//  T_SECAR   120   ticks for centrifuge (drives secar)
// PORTS
//  clock            in   1      system clock, rising edge
//  reset_n          in   1      asynchronous, active-low reset
//  modo_agitar      in   1      controller agitation mode
//  modo_girar       in   1      controller spin/soak mode
//  modo_centrifugar in   1      controller centrifuge mode
//  pausa            in   1      1 = freeze prescaler and counter
//  tempo1           out  1      first agitation complete (level)
//  tempo2           out  1      spin phase complete (level)
//  tempo3           out  1      second agitation complete (level)
//  secar            out  1      centrifuge complete (level)
//  tempo_restante   out  CNT_W  ticks remaining in current phase
//  fase             out  3      0 IDLE,1 AGIT1,2 GIRAR,3 AGIT2,4 DRENO,5 CENTRIF
//  erro             out  1      sticky: illegal mode pattern detected
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, prescaler 0, all outputs 0, erro 0.
//  - Modes sampled each rising edge; >1 mode high at once is always illegal.
//  - Transitions (else stay): IDLE: agitar->AGIT1. AGIT1: girar->GIRAR. GIRAR: agitar->AGIT2.
//    AGIT2: all modes 0->DRENO. DRENO: centrifugar->CENTRIF. CENTRIF: all 0->IDLE.
//  - Stay conditions: IDLE/DRENO all 0; AGIT1/AGIT2 agitar only; GIRAR girar only;
//    CENTRIF centrifugar only. Any other pattern: erro<=1, state->IDLE same edge.
//  - AGIT1/GIRAR/AGIT2/CENTRIF with all modes 0 (controller reset): ->IDLE, erro unchanged... 
//    except AGIT2 and CENTRIF where all-0 is the legal advance.
//  - Phase entry edge: counter loads phase duration, prescaler clears to 0.
//  - Prescaler counts 0..TICK_DIV-1 while counter>0 and pausa=0; at TICK_DIV-1 wraps
//    and counter decrements. Counter saturates at 0; never wraps below.
//  - Completion outputs registered: asserted the edge after counter==0 in the matching
//    phase; held until state leaves that phase, cleared on the leaving edge.
//    Latency entry-edge -> output = T*TICK_DIV + 1 cycles (pausa low). T=0 -> 1 cycle.
//  - pausa freezes counter and prescaler; does not affect state or held outputs.
//  - DRENO and IDLE: counter 0, prescaler idle, no completion output.
//  - tempo_restante = counter; fase = state encoding; both combinational from registers.
//  - erro clears only on reset_n. Reset mid-phase: immediate return to reset values.
// TESTING
//  - TICK_DIV=2,T_AGITAR=3: agitar high from edge 0 -> tempo1 rises at edge 7, fase=1.
//  - Full cycle agitar->girar->agitar->0->centrifugar->0 held per completion -> tempo1,
//    tempo2, tempo3, secar each pulse in order, fase 1,2,3,4,5,0, erro stays 0.
//  - pausa high 4 cycles mid-AGIT1 (TICK_DIV=2,T=3) -> tempo1 delayed to edge 11.
//  - agitar and girar both high in AGIT1 -> erro=1, fase=0, outputs 0; persists to reset.
//  - T_GIRAR=0 -> tempo2 asserts 1 cycle after GIRAR entry; tempo_restante reads 0.
//  - reset_n low mid-CENTRIF with tempo_restante=50 -> all outputs 0, fase 0 asynchronously.

Source files
------------

// File: rtl/temporizador_lavagem.sv
// Phase timer for the washing-machine controller: tracks the controller's mode outputs,
// times each wash phase and returns level completion flags plus remaining time / phase.
//  state   | meaning
//  IDLE    | no cycle in progress
//  AGIT1   | first agitation, timing T_AGITAR
//  GIRAR   | spin/soak, timing T_GIRAR
//  AGIT2   | second agitation, timing T_AGITAR2
//  DRENO   | drain, waiting for centrifuge request
//  CENTRIF | centrifuge, timing T_SECAR
module temporizador_lavagem #(
  parameter int CNT_W     = 16,
  parameter int TICK_DIV  = 50000,
  parameter int T_AGITAR  = 60,
  parameter int T_GIRAR   = 30,
  parameter int T_AGITAR2 = 60,
  parameter int T_SECAR   = 120
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             modo_agitar,
  input  logic             modo_girar,
  input  logic             modo_centrifugar,
  input  logic             pausa,
  output logic             tempo1,
  output logic             tempo2,
  output logic             tempo3,
  output logic             secar,
  output logic [CNT_W-1:0] tempo_restante,
  output logic [2:0]       fase,
  output logic             erro
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AGIT1   = 3'd1,
    GIRAR   = 3'd2,
    AGIT2   = 3'd3,
    DRENO   = 3'd4,
    CENTRIF = 3'd5
  } state_t;

  state_t           state, nxt;
  logic             ilegal;
  logic [CNT_W-1:0] counter, dur_nxt;
  logic [PW-1:0]    presc;
  logic             ag, gi, ce, any_modo, multi;

  assign ag       = modo_agitar;
  assign gi       = modo_girar;
  assign ce       = modo_centrifugar;
  assign any_modo = ag | gi | ce;
  assign multi    = (ag & gi) | (ag & ce) | (gi & ce);

  // All-zero modes in a timed phase means the controller was reset: back to IDLE
  // without flagging, except in AGIT2/CENTRIF where all-zero is the normal advance.
  always_comb begin
    nxt    = state;
    ilegal = 1'b0;
    if (multi) begin
      ilegal = 1'b1;
    end else begin
      case (state)
        IDLE:    if (ag) nxt = AGIT1; else if (gi | ce) ilegal = 1'b1;
        AGIT1:   if (gi) nxt = GIRAR; else if (ce) ilegal = 1'b1; else if (!ag) nxt = IDLE;
        GIRAR:   if (ag) nxt = AGIT2; else if (ce) ilegal = 1'b1; else if (!gi) nxt = IDLE;
        AGIT2:   if (!any_modo) nxt = DRENO; else if (!ag) ilegal = 1'b1;
        DRENO:   if (ce) nxt = CENTRIF; else if (any_modo) ilegal = 1'b1;
        CENTRIF: if (!any_modo) nxt = IDLE; else if (!ce) ilegal = 1'b1;
        default: nxt = IDLE;
      endcase
    end
    if (ilegal) nxt = IDLE;
  end

  always_comb begin
    dur_nxt = '0;
    case (nxt)
      AGIT1:   dur_nxt = CNT_W'(T_AGITAR);
      GIRAR:   dur_nxt = CNT_W'(T_GIRAR);
      AGIT2:   dur_nxt = CNT_W'(T_AGITAR2);
      CENTRIF: dur_nxt = CNT_W'(T_SECAR);
      default: dur_nxt = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      counter <= '0;
      presc   <= '0;
      tempo1  <= 1'b0;
      tempo2  <= 1'b0;
      tempo3  <= 1'b0;
      secar   <= 1'b0;
      erro    <= 1'b0;
    end else begin
      state <= nxt;
      if (ilegal) erro <= 1'b1;
      if (nxt != state) begin
        counter <= dur_nxt;
        presc   <= '0;
      end else if (counter != '0 && !pausa) begin
        if (presc == PRESC_LAST) begin
          presc   <= '0;
          counter <= counter - 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      // Completion is a level held while the phase persists; leaving clears it.
      tempo1 <= (state == AGIT1)   && (nxt == AGIT1)   && (counter == '0);
      tempo2 <= (state == GIRAR)   && (nxt == GIRAR)   && (counter == '0);
      tempo3 <= (state == AGIT2)   && (nxt == AGIT2)   && (counter == '0);
      secar  <= (state == CENTRIF) && (nxt == CENTRIF) && (counter == '0);
    end
  end

  assign tempo_restante = counter;
  assign fase           = state;

endmodule

// File: tb/tb_temporizador_lavagem.sv
// Directed bench for temporizador_lavagem with short durations (TICK_DIV=2).
module tb_temporizador_lavagem;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        modo_agitar = 1'b0, modo_girar = 1'b0, modo_centrifugar = 1'b0, pausa = 1'b0;
  logic        tempo1, tempo2, tempo3, secar, erro;
  logic [15:0] tempo_restante;
  logic [2:0]  fase;

  int n_vec = 0;
  int n_err = 0;

  temporizador_lavagem #(
    .CNT_W(16), .TICK_DIV(2), .T_AGITAR(3), .T_GIRAR(0), .T_AGITAR2(2), .T_SECAR(60)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .modo_agitar(modo_agitar), .modo_girar(modo_girar), .modo_centrifugar(modo_centrifugar),
    .pausa(pausa),
    .tempo1(tempo1), .tempo2(tempo2), .tempo3(tempo3), .secar(secar),
    .tempo_restante(tempo_restante), .fase(fase), .erro(erro)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic modos(input logic a, input logic g, input logic c);
    modo_agitar = a; modo_girar = g; modo_centrifugar = c;
  endtask

  task automatic chk_outs(input string tag, input int f, input int t1, input int t2,
                          input int t3, input int s, input int e);
    chk({tag, ".fase"}, int'(fase), f);
    chk({tag, ".tempo1"}, int'(tempo1), t1);
    chk({tag, ".tempo2"}, int'(tempo2), t2);
    chk({tag, ".tempo3"}, int'(tempo3), t3);
    chk({tag, ".secar"}, int'(secar), s);
    chk({tag, ".erro"}, int'(erro), e);
  endtask

  initial begin
    #12;
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.rest", int'(tempo_restante), 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    // Full wash cycle; agitar applied before edge 0
    modos(1, 0, 0);
    step(1);
    chk_outs("agit1_entry", 1, 0, 0, 0, 0, 0);
    chk("agit1_entry.rest", int'(tempo_restante), 3);
    step(6);
    chk("agit1_e6.rest", int'(tempo_restante), 0);
    chk("agit1_e6.tempo1", int'(tempo1), 0);
    step(1);
    chk_outs("agit1_e7", 1, 1, 0, 0, 0, 0);
    step(3);
    chk("agit1_hold.tempo1", int'(tempo1), 1);

    modos(0, 1, 0);
    step(1);
    chk_outs("girar_entry", 2, 0, 0, 0, 0, 0);
    chk("girar_entry.rest", int'(tempo_restante), 0);
    step(1);
    chk_outs("girar_done", 2, 0, 1, 0, 0, 0);

    modos(1, 0, 0);
    step(1);
    chk_outs("agit2_entry", 3, 0, 0, 0, 0, 0);
    chk("agit2_entry.rest", int'(tempo_restante), 2);
    step(4);
    chk("agit2_e4.tempo3", int'(tempo3), 0);
    step(1);
    chk_outs("agit2_done", 3, 0, 0, 1, 0, 0);

    modos(0, 0, 0);
    step(1);
    chk_outs("dreno", 4, 0, 0, 0, 0, 0);
    chk("dreno.rest", int'(tempo_restante), 0);
    step(3);
    chk("dreno_hold.fase", int'(fase), 4);

    modos(0, 0, 1);
    step(1);
    chk_outs("centrif_entry", 5, 0, 0, 0, 0, 0);
    chk("centrif_entry.rest", int'(tempo_restante), 60);
    step(120);
    chk("centrif_e120.rest", int'(tempo_restante), 0);
    chk("centrif_e120.secar", int'(secar), 0);
    step(1);
    chk_outs("centrif_done", 5, 0, 0, 0, 1, 0);

    modos(0, 0, 0);
    step(1);
    chk_outs("cycle_end", 0, 0, 0, 0, 0, 0);

    // Pause four cycles mid-AGIT1: completion moves from edge 7 to edge 11
    modos(1, 0, 0);
    step(1);
    chk("pausa_entry.fase", int'(fase), 1);
    step(2);
    chk("pausa_pre.rest", int'(tempo_restante), 2);
    pausa = 1'b1;
    step(4);
    chk("pausa_frozen.rest", int'(tempo_restante), 2);
    chk("pausa_frozen.fase", int'(fase), 1);
    pausa = 1'b0;
    step(4);
    chk("pausa_e10.rest", int'(tempo_restante), 0);
    chk("pausa_e10.tempo1", int'(tempo1), 0);
    step(1);
    chk("pausa_e11.tempo1", int'(tempo1), 1);
    pausa = 1'b1;
    step(2);
    chk("pausa_held.tempo1", int'(tempo1), 1);
    pausa = 1'b0;

    // Two modes at once in AGIT1
    modos(1, 1, 0);
    step(1);
    chk_outs("multi", 0, 0, 0, 0, 0, 1);
    chk("multi.rest", int'(tempo_restante), 0);
    modos(0, 0, 0);
    step(3);
    chk("erro_sticky_idle", int'(erro), 1);
    modos(1, 0, 0);
    step(1);
    chk("erro_sticky_agit.fase", int'(fase), 1);
    chk("erro_sticky_agit.erro", int'(erro), 1);
    modos(0, 0, 0);
    step(1);
    chk("abort_to_idle.fase", int'(fase), 0);
    reset_n = 1'b0;
    #1;
    chk("erro_cleared", int'(erro), 0);
    reset_n = 1'b1;
    step(1);

    // Lone girar from IDLE is illegal
    modos(0, 1, 0);
    step(1);
    chk("idle_girar.erro", int'(erro), 1);
    chk("idle_girar.fase", int'(fase), 0);
    modos(0, 0, 0);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    step(1);

    // Asynchronous reset mid-CENTRIF
    modos(1, 0, 0); step(1);
    modos(0, 1, 0); step(1);
    modos(1, 0, 0); step(1);
    modos(0, 0, 0); step(1);
    modos(0, 0, 1); step(1);
    chk("rst_mid.entry_fase", int'(fase), 5);
    step(20);
    chk("rst_mid.rest50", int'(tempo_restante), 50);
    reset_n = 1'b0;
    #1;
    chk_outs("rst_mid_async", 0, 0, 0, 0, 0, 0);
    chk("rst_mid_async.rest", int'(tempo_restante), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
